// File: rtl/send_scheduler_pkg.sv
// Shared types for the tx send scheduler: FSM states, ordering modes and the
// zero-means-one clamp applied to segment count and redundancy.
package send_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    ACK   = 3'd2,
    DRAIN = 3'd3,
    ADV   = 3'd4,
    HOLD  = 3'd5
  } state_t;

  localparam logic MODE_FRAME_MAJOR = 1'b0;
  localparam logic MODE_SEG_MAJOR   = 1'b1;

  function automatic logic [31:0] clamp_min1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/send_scheduler_if.sv
// Start/busy handshake and frame descriptor between the send scheduler and
// the UDP frame builder.
interface send_scheduler_if #(
  parameter int SEG_W  = 16,
  parameter int TXID_W = 8,
  parameter int AUX_W  = 8
);
  logic              start_sending;
  logic [SEG_W-1:0]  segment_num;
  logic [TXID_W-1:0] txid;
  logic              first_copy;
  logic [AUX_W-1:0]  aux;
  logic              busy;

  modport master (
    output start_sending, segment_num, txid, first_copy, aux,
    input  busy
  );

  modport slave (
    input  start_sending, segment_num, txid, first_copy, aux,
    output busy
  );
endinterface

// File: rtl/send_scheduler_pos_counter.sv
// Nested segment/copy position counter; mode selects which index is inner.
// wrap flags that the next advance finishes the round.
module send_pos_counter
  import send_pkg::*;
#(
  parameter int SEG_W  = 16,
  parameter int TXID_W = 8
) (
  input  logic              clk125MHz,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic              mode,
  input  logic [SEG_W-1:0]  seg_max,
  input  logic [TXID_W-1:0] red,
  output logic [SEG_W-1:0]  seg,
  output logic [TXID_W-1:0] txid,
  output logic              wrap
);

  logic seg_last;
  logic txid_last;

  assign seg_last  = (seg == seg_max - SEG_W'(1));
  assign txid_last = (txid == red);
  assign wrap      = seg_last && txid_last;

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      seg  <= '0;
      txid <= TXID_W'(1);
    end else if (clear) begin
      seg  <= '0;
      txid <= TXID_W'(1);
    end else if (advance) begin
      if (mode == MODE_SEG_MAJOR) begin
        if (txid_last) begin
          txid <= TXID_W'(1);
          seg  <= seg_last ? '0 : seg + SEG_W'(1);
        end else begin
          txid <= txid + TXID_W'(1);
        end
      end else begin
        if (seg_last) begin
          seg  <= '0;
          txid <= txid_last ? TXID_W'(1) : txid + TXID_W'(1);
        end else begin
          seg <= seg + SEG_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/send_scheduler.sv
// Issues start pulses to the frame builder, pacing them by an idle gap and a
// busy acknowledge with timeout; config is sampled once per round.
module send_scheduler
  import send_pkg::*;
#(
  parameter int SEG_W  = 16,
  parameter int TXID_W = 8,
  parameter int AUX_W  = 8,
  parameter int GAP_W  = 28,
  parameter int ACK_TO = 16
) (
  input  logic              clk125MHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic [SEG_W-1:0]  segment_num_max,
  input  logic [TXID_W-1:0] redundancy,
  input  logic [GAP_W-1:0]  gap_cycles,
  output logic              round_done,
  output logic              ack_err,
  send_scheduler_if.master  tx
);

  // state | meaning
  // IDLE  | not started; enable latches config and starts at (0,1)
  // GAP   | counting idle cycles; fires start or parks in HOLD on pause
  // ACK   | start issued, waiting for busy (timeout sets ack_err)
  // DRAIN | builder busy, waiting for it to finish
  // ADV   | step position; round end bumps aux and re-latches config
  // HOLD  | paused, position frozen until enable returns

  localparam int ACK_W = $clog2(ACK_TO + 1);

  state_t            state, state_nxt;
  logic              latch_cfg, pos_clear, pos_adv, fire, ack_timeout, round_end;
  logic [SEG_W-1:0]  seg_max_q, pos_seg, seg_q;
  logic [TXID_W-1:0] red_q, pos_txid, txid_q;
  logic              mode_q, pos_wrap, start_q;
  logic [AUX_W-1:0]  aux_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ACK_W-1:0]  ack_cnt;

  send_pos_counter #(.SEG_W(SEG_W), .TXID_W(TXID_W)) u_pos (
    .clk125MHz (clk125MHz),
    .rst_n     (rst_n),
    .clear     (pos_clear),
    .advance   (pos_adv),
    .mode      (mode_q),
    .seg_max   (seg_max_q),
    .red       (red_q),
    .seg       (pos_seg),
    .txid      (pos_txid),
    .wrap      (pos_wrap)
  );

  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    latch_cfg   = 1'b0;
    pos_clear   = 1'b0;
    pos_adv     = 1'b0;
    fire        = 1'b0;
    ack_timeout = 1'b0;
    round_end   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          latch_cfg = 1'b1;
          pos_clear = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (!enable) begin
          state_nxt = HOLD;
        end else if (!tx.busy && gap_cnt >= gap_cycles) begin
          fire      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (tx.busy) begin
          state_nxt = DRAIN;
        end else if (ack_cnt == ACK_W'(ACK_TO - 1)) begin
          ack_timeout = 1'b1;
          state_nxt   = ADV;
        end
      end
      DRAIN: begin
        if (!tx.busy) state_nxt = ADV;
      end
      ADV: begin
        pos_adv   = 1'b1;
        round_end = pos_wrap;
        latch_cfg = pos_wrap;
        state_nxt = GAP;
      end
      HOLD: begin
        if (enable) state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Descriptor outputs are captured at the start so they hold for the whole frame.
  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      seg_max_q  <= '0;
      red_q      <= '0;
      mode_q     <= MODE_FRAME_MAJOR;
      gap_cnt    <= '0;
      ack_cnt    <= '0;
      start_q    <= 1'b0;
      seg_q      <= '0;
      txid_q     <= TXID_W'(1);
      aux_q      <= '0;
      round_done <= 1'b0;
      ack_err    <= 1'b0;
    end else begin
      start_q    <= fire;
      round_done <= round_end;
      if (round_end)   aux_q   <= aux_q + AUX_W'(1);
      if (ack_timeout) ack_err <= 1'b1;
      if (latch_cfg) begin
        seg_max_q <= SEG_W'(clamp_min1(32'(segment_num_max)));
        red_q     <= TXID_W'(clamp_min1(32'(redundancy)));
        mode_q    <= mode;
      end
      if (fire) begin
        seg_q  <= pos_seg;
        txid_q <= pos_txid;
      end
      if (state != GAP || tx.busy || fire) gap_cnt <= '0;
      else if (gap_cnt < gap_cycles)       gap_cnt <= gap_cnt + GAP_W'(1);
      if (state != ACK) ack_cnt <= '0;
      else              ack_cnt <= ack_cnt + ACK_W'(1);
    end
  end

  assign tx.start_sending = start_q;
  assign tx.segment_num   = seg_q;
  assign tx.txid          = txid_q;
  assign tx.first_copy    = (txid_q == TXID_W'(1));
  assign tx.aux           = aux_q;

endmodule

// File: tb/tb_send_scheduler.sv
// Directed bench for send_scheduler with a simple builder model that holds
// busy for a programmable number of cycles after each start.
module tb_send_scheduler;
  import send_pkg::*;

  logic        clk125MHz = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mode;
  logic [15:0] segment_num_max;
  logic [7:0]  redundancy;
  logic [27:0] gap_cycles;
  logic        round_done;
  logic        ack_err;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int rd_cnt   = 0;
  bit busy_en;
  int busy_len;
  logic [7:0] bcnt = 8'd0;

  send_scheduler_if #(.SEG_W(16), .TXID_W(8), .AUX_W(8)) sif ();

  send_scheduler #(
    .SEG_W(16), .TXID_W(8), .AUX_W(8), .GAP_W(28), .ACK_TO(16)
  ) dut (
    .clk125MHz       (clk125MHz),
    .rst_n           (rst_n),
    .enable          (enable),
    .mode            (mode),
    .segment_num_max (segment_num_max),
    .redundancy      (redundancy),
    .gap_cycles      (gap_cycles),
    .round_done      (round_done),
    .ack_err         (ack_err),
    .tx              (sif)
  );

  always #4 clk125MHz = ~clk125MHz;

  always @(posedge clk125MHz) begin
    cycle <= cycle + 1;
    if (!busy_en)               bcnt <= 8'd0;
    else if (sif.start_sending) bcnt <= 8'(busy_len);
    else if (bcnt != 8'd0)      bcnt <= bcnt - 8'd1;
  end
  assign sif.busy = (bcnt != 8'd0);

  always @(negedge clk125MHz) if (round_done) rd_cnt <= rd_cnt + 1;

  task automatic wait_start(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk125MHz);
      if (sif.start_sending) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0; mode = MODE_FRAME_MAJOR;
    segment_num_max = 16'd1; redundancy = 8'd1; gap_cycles = 28'd0;
    busy_en = 1'b1; busy_len = 10;
    repeat (3) @(negedge clk125MHz);
    rst_n = 1'b1;
    @(negedge clk125MHz);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sif.start_sending !== 1'b0 || sif.segment_num !== 16'd0 || sif.txid !== 8'd1 ||
        sif.first_copy !== 1'b1 || sif.aux !== 8'd0 || round_done !== 1'b0 || ack_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got start=%b seg=%0d txid=%0d fc=%b aux=%0d rd=%b err=%b want 0 0 1 1 0 0 0",
               sif.start_sending, sif.segment_num, sif.txid, sif.first_copy, sif.aux, round_done, ack_err);
    end
  endtask

  task automatic test_frame_major();
    int exp_seg[6]  = '{0, 1, 2, 0, 1, 2};
    int exp_txid[6] = '{1, 1, 1, 2, 2, 2};
    int prev = 0;
    int rd0;
    bit got;
    do_reset();
    segment_num_max = 16'd3; redundancy = 8'd2; gap_cycles = 28'd5; busy_len = 10;
    rd0 = rd_cnt;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_start(200, got);
      checks++;
      if (!got || sif.segment_num !== 16'(exp_seg[k]) || sif.txid !== 8'(exp_txid[k])) begin
        failures++;
        $display("FAIL fm_pos[%0d] got start=%b seg=%0d txid=%0d want seg=%0d txid=%0d",
                 k, got, sif.segment_num, sif.txid, exp_seg[k], exp_txid[k]);
      end
      if (k > 0) begin
        checks++;
        if (cycle - prev != 19) begin
          failures++;
          $display("FAIL fm_spacing[%0d] got %0d want 19", k, cycle - prev);
        end
      end
      prev = cycle;
    end
    checks++;
    if (sif.aux !== 8'd0) begin
      failures++;
      $display("FAIL fm_aux_before got %0d want 0", sif.aux);
    end
    enable = 1'b0;
    repeat (40) @(negedge clk125MHz);
    checks++;
    if (rd_cnt - rd0 != 1 || sif.aux !== 8'd1) begin
      failures++;
      $display("FAIL fm_round got round_done=%0d aux=%0d want 1 1", rd_cnt - rd0, sif.aux);
    end
  endtask

  task automatic test_seg_major();
    int exp_seg[6]  = '{0, 0, 0, 1, 1, 1};
    int exp_txid[6] = '{1, 2, 3, 1, 2, 3};
    bit got;
    logic exp_fc;
    do_reset();
    mode = MODE_SEG_MAJOR; segment_num_max = 16'd2; redundancy = 8'd3;
    gap_cycles = 28'd2; busy_len = 3;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_start(100, got);
      exp_fc = (exp_txid[k] == 1);
      checks++;
      if (!got || sif.segment_num !== 16'(exp_seg[k]) || sif.txid !== 8'(exp_txid[k]) ||
          sif.first_copy !== exp_fc) begin
        failures++;
        $display("FAIL sm_pos[%0d] got start=%b seg=%0d txid=%0d fc=%b want seg=%0d txid=%0d fc=%b",
                 k, got, sif.segment_num, sif.txid, sif.first_copy, exp_seg[k], exp_txid[k], exp_fc);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_zero_config();
    int rd0;
    bit got;
    do_reset();
    segment_num_max = 16'd0; redundancy = 8'd0; gap_cycles = 28'd0; busy_len = 4;
    rd0 = rd_cnt;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start(60, got);
      checks++;
      if (!got || sif.segment_num !== 16'd0 || sif.txid !== 8'd1 || sif.aux !== 8'(k) ||
          rd_cnt - rd0 != k) begin
        failures++;
        $display("FAIL zero_cfg[%0d] got start=%b seg=%0d txid=%0d aux=%0d rounds=%0d want 0 1 %0d %0d",
                 k, got, sif.segment_num, sif.txid, sif.aux, rd_cnt - rd0, k, k);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_pause();
    bit got;
    do_reset();
    segment_num_max = 16'd3; redundancy = 8'd2; gap_cycles = 28'd3; busy_len = 6;
    enable = 1'b1;
    wait_start(100, got);
    wait_start(100, got);
    checks++;
    if (!got || sif.segment_num !== 16'd1 || sif.txid !== 8'd1) begin
      failures++;
      $display("FAIL pause_second got start=%b seg=%0d txid=%0d want seg=1 txid=1",
               got, sif.segment_num, sif.txid);
    end
    enable = 1'b0;
    wait_start(50, got);
    checks++;
    if (got) begin
      failures++;
      $display("FAIL pause_hold got start while paused want none");
    end
    enable = 1'b1;
    wait_start(100, got);
    checks++;
    if (!got || sif.segment_num !== 16'd2 || sif.txid !== 8'd1) begin
      failures++;
      $display("FAIL pause_resume got start=%b seg=%0d txid=%0d want seg=2 txid=1",
               got, sif.segment_num, sif.txid);
    end
    enable = 1'b0;
  endtask

  task automatic test_ack_timeout();
    bit got;
    int c0;
    do_reset();
    busy_en = 1'b0;
    segment_num_max = 16'd2; redundancy = 8'd1; gap_cycles = 28'd0;
    enable = 1'b1;
    wait_start(40, got);
    checks++;
    if (!got || ack_err !== 1'b0) begin
      failures++;
      $display("FAIL ack_first got start=%b err=%b want start=1 err=0", got, ack_err);
    end
    c0 = cycle;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk125MHz);
      if (ack_err) break;
    end
    checks++;
    if (ack_err !== 1'b1 || cycle - c0 != 16) begin
      failures++;
      $display("FAIL ack_timeout got err=%b after %0d cycles want 1 after 16", ack_err, cycle - c0);
    end
    wait_start(40, got);
    checks++;
    if (!got || sif.segment_num !== 16'd1) begin
      failures++;
      $display("FAIL ack_continue got start=%b seg=%0d want start=1 seg=1", got, sif.segment_num);
    end
    enable = 1'b0;
    busy_en = 1'b1;
    repeat (30) @(negedge clk125MHz);
    checks++;
    if (ack_err !== 1'b1) begin
      failures++;
      $display("FAIL ack_sticky got %b want 1", ack_err);
    end
  endtask

  task automatic test_cfg_change();
    int exp_seg[5] = '{0, 1, 0, 1, 2};
    int rd0;
    bit got;
    do_reset();
    segment_num_max = 16'd2; redundancy = 8'd1; gap_cycles = 28'd1; busy_len = 3;
    rd0 = rd_cnt;
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start(60, got);
      if (k == 0) segment_num_max = 16'd3;
      checks++;
      if (!got || sif.segment_num !== 16'(exp_seg[k]) || sif.txid !== 8'd1) begin
        failures++;
        $display("FAIL cfg_change[%0d] got start=%b seg=%0d txid=%0d want seg=%0d txid=1",
                 k, got, sif.segment_num, sif.txid, exp_seg[k]);
      end
    end
    checks++;
    if (rd_cnt - rd0 != 1) begin
      failures++;
      $display("FAIL cfg_rounds got %0d want 1", rd_cnt - rd0);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    bit got;
    do_reset();
    segment_num_max = 16'd2; redundancy = 8'd1; gap_cycles = 28'd0; busy_len = 10;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) wait_start(60, got);
    checks++;
    if (!got || sif.segment_num !== 16'd1 || sif.aux !== 8'd1) begin
      failures++;
      $display("FAIL drain_pre got start=%b seg=%0d aux=%0d want 1 1 1", got, sif.segment_num, sif.aux);
    end
    repeat (4) @(negedge clk125MHz);
    #1 rst_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++;
    if (sif.start_sending !== 1'b0 || sif.segment_num !== 16'd0 || sif.txid !== 8'd1 ||
        sif.first_copy !== 1'b1 || sif.aux !== 8'd0 || round_done !== 1'b0) begin
      failures++;
      $display("FAIL drain_async_reset got start=%b seg=%0d txid=%0d fc=%b aux=%0d rd=%b want 0 0 1 1 0 0",
               sif.start_sending, sif.segment_num, sif.txid, sif.first_copy, sif.aux, round_done);
    end
    @(negedge clk125MHz);
    rst_n = 1'b1;
    wait_start(30, got);
    checks++;
    if (got) begin
      failures++;
      $display("FAIL drain_no_pending got start after reset want none");
    end
  endtask

  task automatic test_aux_wrap();
    bit got;
    int missed = 0;
    do_reset();
    segment_num_max = 16'd0; redundancy = 8'd0; gap_cycles = 28'd0; busy_len = 1;
    enable = 1'b1;
    for (int k = 0; k < 256; k++) begin
      wait_start(20, got);
      if (!got) missed++;
    end
    checks++;
    if (missed != 0 || sif.aux !== 8'd255) begin
      failures++;
      $display("FAIL aux_255 got aux=%0d missed=%0d want 255 0", sif.aux, missed);
    end
    wait_start(20, got);
    checks++;
    if (!got || sif.aux !== 8'd0) begin
      failures++;
      $display("FAIL aux_wrap got start=%b aux=%0d want 1 0", got, sif.aux);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_major();
    test_seg_major();
    test_zero_config();
    test_pause();
    test_ack_timeout();
    test_cfg_change();
    test_reset_mid_drain();
    test_aux_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
